fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 Stall_i  input  1  downstream cannot accept; hold outputs and PC.
REQ-005 Branch_i  input  1  taken-branch redirect request (single-cycle pulse).
REQ-006 BranchTarget_i  input  32  branch target address.
REQ-007 Jump_i  input  1  jump redirect request (single-cycle pulse).
REQ-008 JumpTarget_i  input  32  jump target address.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  32  fetch address; equals internal PC.
REQ-011 imem_ack_i  input  1  one-cycle data-valid strobe for the outstanding request.
REQ-012 imem_data_i  input  32  instruction word, valid when imem_ack_i=1.
REQ-013 PC_o  output  32  PC+4 of presented instruction, to IF/ID register.
REQ-014 instruction_o  output  32  presented instruction word.
REQ-015 valid_o  output  1  instruction_o/PC_o hold a real instruction.
REQ-016 Flush_o  output  1  one-cycle pulse: younger in-flight instruction is killed.
REQ-017 Misalign_o  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-018 States: FETCH (request outstanding), HOLD (word buffered, Stall_i high), DRAIN (discard stale response after redirect).
REQ-019 FETCH: imem_req_o=1, imem_addr_o=PC held stable until imem_ack_i; ack in the same cycle as request (zero wait) is legal.
REQ-020 FETCH, ack, Stall_i=0: instruction_o<=imem_data_i, PC_o<=PC+4, valid_o<=1, PC<=PC+4; stay FETCH.
REQ-021 FETCH, no ack, Stall_i=0: valid_o<=0 (bubble); instruction_o/PC_o hold.
REQ-022 FETCH, ack, Stall_i=1: buffer word internally, PC unchanged, outputs hold; go HOLD.
REQ-023 FETCH, Stall_i=1, no ack: outputs hold; request stays outstanding.
REQ-024 HOLD: imem_req_o=0; when Stall_i=0 present buffered word (valid_o<=1, PC_o<=PC+4), PC<=PC+4, go FETCH.
REQ-025 Redirect (Branch_i or Jump_i) in any state: PC<=target, valid_o<=0, Flush_o=1 that cycle; Branch_i wins if both high.
REQ-026 Redirect has priority over Stall_i and discards any HOLD buffer.
REQ-027 Redirect in FETCH without ack: go DRAIN; imem_req_o=0; next ack discarded, then FETCH at new PC.
REQ-028 Redirect in FETCH with ack same cycle, or in HOLD: data discarded, go FETCH directly.
REQ-029 Redirect in DRAIN: update PC only; remain DRAIN until the stale ack.
REQ-030 PC arithmetic modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-031 Flush_o combinational from Branch_i|Jump_i; all other outputs registered.

Reset
REQ-032 rst_i=1 at a clock edge: PC<=RESET_PC, state<=FETCH, valid_o<=0, instruction_o<=0, PC_o<=0, Misalign_o<=0, buffer cleared; overrides all inputs.
REQ-033 Reset mid-request: an ack arriving in the first post-reset cycle is accepted as response to RESET_PC (memory is reset together).

Configuration
REQ-034 Macro FETCH_ALIGN_CHECK_EN defined: redirect target with bits[1:0]!=0 sets Misalign_o (sticky until reset) and PC loads target with bits[1:0] cleared.
REQ-035 Macro undefined: target loaded unmodified; Misalign_o tied 0.

Verification
REQ-036 Reset, ack every cycle, Stall_i=0 -> addresses 0,4,8; PC_o 4,8,12; valid_o 1 from second edge.
REQ-037 Ack on third cycle of each request -> valid_o pulses once per word; imem_addr_o stable while waiting.
REQ-038 Stall_i high 3 cycles during ack of word at 0x10 -> outputs frozen, req low in HOLD; release -> word at 0x10 presented once, next fetch 0x14.
REQ-039 Branch_i to 0x200 with unacked request at 0x20 -> Flush_o=1 one cycle, late ack discarded, next request at 0x200, no stale valid_o.
REQ-040 Branch_i and Jump_i together (0x100/0x300) -> fetch 0x100; Jump with target 0x302 -> with macro Misalign_o=1, fetch 0x300; without, fetch 0x302.
REQ-041 rst_i mid-HOLD -> next edge valid_o=0, imem_addr_o=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
//   Instruction-memory request/response bus between the fetch unit and
//   the instruction memory.
//   imem_req_o   fetch unit -> memory : request strobe (level, held until ack)
//   imem_addr_o  fetch unit -> memory : 32-bit fetch address
//   imem_ack_i   memory -> fetch unit : one-cycle data-valid strobe
//   imem_data_i  memory -> fetch unit : 32-bit instruction word
//   modport master : fetch unit side
//   modport slave  : memory side
interface fetch_unit_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_ack_i,
        input  imem_data_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ack_i,
        output imem_data_i
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. It keeps the PC, issues one outstanding request
//   at a time on the imem bus, and presents each returned word (with PC+4) to
//   the IF/ID register. It holds its outputs under Stall_i and redirects on
//   Branch_i / Jump_i.
//
//   Parameter RESET_PC      : PC value loaded on reset.
//   Optional feature macro  : FETCH_ALIGN_CHECK_EN
//       defined   -> a redirect target with bits[1:0] != 0 sets the sticky
//                    Misalign_o flag, and the PC loads the target with
//                    bits[1:0] cleared.
//       undefined -> the target is loaded unmodified and Misalign_o is 0.
//
//   Ports
//   clk_i            : clock; all state changes on the rising edge
//   rst_i            : synchronous active-high reset
//   Stall_i          : downstream cannot accept; hold the outputs and the PC
//   Branch_i         : taken-branch redirect (wins over Jump_i)
//   BranchTarget_i   : branch target address
//   Jump_i           : jump redirect
//   JumpTarget_i     : jump target address
//   imem             : instruction memory bus (fetch_unit_if.master)
//   PC_o             : PC+4 of the presented instruction
//   instruction_o    : presented instruction word
//   valid_o          : PC_o / instruction_o hold a real instruction
//   Flush_o          : combinational; high in any cycle with a redirect
//   Misalign_o       : sticky misaligned-target flag
//
//   state   | meaning
//   S_FETCH | a request for r_pc is outstanding on the bus
//   S_HOLD  | the word for r_pc is buffered while Stall_i is high
//   S_DRAIN | a redirect orphaned a request; its ack is thrown away
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        Branch_i,
    input  logic [31:0] BranchTarget_i,
    input  logic        Jump_i,
    input  logic [31:0] JumpTarget_i,
    fetch_unit_if.master imem,
    output logic [31:0] PC_o,
    output logic [31:0] instruction_o,
    output logic        valid_o,
    output logic        Flush_o,
    output logic        Misalign_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr;
    logic        r_valid;
    logic        r_req;

    logic        w_redirect;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic [31:0] w_pc_inc;

    assign w_redirect   = Branch_i | Jump_i;
    assign w_target_raw = Branch_i ? BranchTarget_i : JumpTarget_i;
    assign w_pc_inc     = r_pc + 32'd4;   // wraps modulo 2^32

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_target = {w_target_raw[31:2], 2'b00};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && (w_target_raw[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign Misalign_o = r_misalign;
`else
    assign w_target   = w_target_raw;
    assign Misalign_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_buf    <= 32'd0;
            r_pc_out <= 32'd0;
            r_instr  <= 32'd0;
            r_valid  <= 1'b0;
            r_req    <= 1'b1;
        end else if (w_redirect) begin
            // A redirect beats Stall_i and throws away any buffered word.
            r_pc    <= w_target;
            r_valid <= 1'b0;
            r_buf   <= 32'd0;
            // If the bus still owes us an ack that is not arriving now,
            // wait for it in DRAIN so it cannot be taken for the new target.
            if (((r_state == S_FETCH) || (r_state == S_DRAIN)) && !imem.imem_ack_i) begin
                r_state <= S_DRAIN;
                r_req   <= 1'b0;
            end else begin
                r_state <= S_FETCH;
                r_req   <= 1'b1;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem.imem_ack_i) begin
                        if (Stall_i) begin
                            r_buf   <= imem.imem_data_i;
                            r_state <= S_HOLD;
                            r_req   <= 1'b0;
                        end else begin
                            r_instr  <= imem.imem_data_i;
                            r_pc_out <= w_pc_inc;
                            r_valid  <= 1'b1;
                            r_pc     <= w_pc_inc;
                        end
                    end else if (!Stall_i) begin
                        r_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!Stall_i) begin
                        r_instr  <= r_buf;
                        r_pc_out <= w_pc_inc;
                        r_valid  <= 1'b1;
                        r_pc     <= w_pc_inc;
                        r_state  <= S_FETCH;
                        r_req    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (imem.imem_ack_i) begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                    r_req   <= 1'b1;
                end
            endcase
        end
    end

    assign imem.imem_req_o  = r_req;
    assign imem.imem_addr_o = r_pc;

    assign PC_o          = r_pc_out;
    assign instruction_o = r_instr;
    assign valid_o       = r_valid;
    assign Flush_o       = w_redirect;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        Stall_i;
    logic        Branch_i;
    logic [31:0] BranchTarget_i;
    logic        Jump_i;
    logic [31:0] JumpTarget_i;
    logic [31:0] PC_o;
    logic [31:0] instruction_o;
    logic        valid_o;
    logic        Flush_o;
    logic        Misalign_o;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .Stall_i        (Stall_i),
        .Branch_i       (Branch_i),
        .BranchTarget_i (BranchTarget_i),
        .Jump_i         (Jump_i),
        .JumpTarget_i   (JumpTarget_i),
        .imem           (bus),
        .PC_o           (PC_o),
        .instruction_o  (instruction_o),
        .valid_o        (valid_o),
        .Flush_o        (Flush_o),
        .Misalign_o     (Misalign_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // memory model state
    bit          m_busy  = 1'b0;
    bit          m_clear = 1'b0;
    logic [31:0] m_addr;
    int          m_wait;
    int          lat_min = 0;
    int          lat_max = 0;

    // reference model: address of the next word that may be presented
    logic [31:0] exp_pc  = RST_PC;
    bit          exp_mis = 1'b0;
    int          n_present = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    function automatic logic [31:0] gen_target();
        logic [31:0] t;
        if ($urandom_range(7, 0) == 0)
            t = 32'hFFFF_FFF0 + (32'($urandom_range(3, 0)) << 2);
        else
            t = 32'($urandom_range(4095, 0)) << 2;
        if ($urandom_range(3, 0) == 0)
            t[1:0] = 2'($urandom_range(3, 1));
        return t;
    endfunction

    // One clock cycle: memory response, input drive, then model update and
    // checks just after the rising edge.
    task automatic cyc(input bit rst, input bit stall, input bit br, input bit jp,
                       input logic [31:0] bt, input logic [31:0] jt);
        logic [31:0] pv_pc;
        logic [31:0] pv_ins;
        logic        pv_val;
        logic [31:0] tgt;
        @(negedge clk_i);
        if (m_clear) m_busy = 1'b0;
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = $urandom;
        if (m_busy && bus.imem_req_o === 1'b1)
            check_val("addr_stable", bus.imem_addr_o, m_addr);
        if (!m_busy && bus.imem_req_o === 1'b1) begin
            m_busy = 1'b1;
            m_addr = bus.imem_addr_o;
            m_wait = $urandom_range(lat_max, lat_min);
        end
        if (m_busy) begin
            if (m_wait == 0) begin
                bus.imem_ack_i  = 1'b1;
                bus.imem_data_i = mem_word(m_addr);
            end else begin
                m_wait--;
            end
        end
        m_clear = bus.imem_ack_i || rst;

        rst_i          = rst;
        Stall_i        = stall;
        Branch_i       = br;
        Jump_i         = jp;
        BranchTarget_i = bt;
        JumpTarget_i   = jt;
        pv_pc  = PC_o;
        pv_ins = instruction_o;
        pv_val = valid_o;
        #1;
        check_val("flush", {31'd0, Flush_o}, {31'd0, (br | jp)});

        @(posedge clk_i);
        #1;
        if (rst) begin
            exp_pc  = RST_PC;
            exp_mis = 1'b0;
            check_val("rst_valid", {31'd0, valid_o}, 32'd0);
            check_val("rst_pc_o", PC_o, 32'd0);
            check_val("rst_instr", instruction_o, 32'd0);
            check_val("rst_req", {31'd0, bus.imem_req_o}, 32'd1);
        end else if (br || jp) begin
            tgt = br ? bt : jt;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) exp_mis = 1'b1;
            tgt[1:0] = 2'b00;
`endif
            exp_pc = tgt;
            check_val("redir_valid", {31'd0, valid_o}, 32'd0);
        end else if (stall) begin
            check_val("stall_valid", {31'd0, valid_o}, {31'd0, pv_val});
            check_val("stall_pc_o", PC_o, pv_pc);
            check_val("stall_instr", instruction_o, pv_ins);
        end else if (valid_o) begin
            check_val("pres_pc_o", PC_o, exp_pc + 32'd4);
            check_val("pres_instr", instruction_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_present++;
        end
        check_val("misalign", {31'd0, Misalign_o}, {31'd0, exp_mis});
        if (bus.imem_req_o === 1'b1)
            check_val("fetch_addr", bus.imem_addr_o, exp_pc);
    endtask

    task automatic do_reset();
        cyc(1, 0, 0, 0, 32'd0, 32'd0);
        cyc(1, 0, 0, 0, 32'd0, 32'd0);
    endtask

    initial begin
        bit lb;
        bit lj;
        bit s;
        bit b;
        bit j;
        bus.imem_ack_i  = 1'b0;
        bus.imem_data_i = 32'd0;
        rst_i = 1'b1; Stall_i = 1'b0; Branch_i = 1'b0; Jump_i = 1'b0;
        BranchTarget_i = 32'd0; JumpTarget_i = 32'd0;

        // zero-wait memory, no stall: one word per cycle
        lat_min = 0; lat_max = 0;
        do_reset();
        n_present = 0;
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);
        check_val("zero_wait_count", 32'(n_present), 32'd6);

        // ack on the third cycle of each request
        lat_min = 2; lat_max = 2;
        do_reset();
        n_present = 0;
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);
        check_val("slow_mem_count", 32'(n_present), 32'd3);

        // stall over the ack of the word at 0x10
        lat_min = 0; lat_max = 0;
        do_reset();
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0, 32'd0, 32'd0);
            check_val("hold_req", {31'd0, bus.imem_req_o}, 32'd0);
        end
        cyc(0, 0, 0, 0, 32'd0, 32'd0);
        check_val("hold_release_pc", PC_o, 32'h14);
        cyc(0, 0, 0, 0, 32'd0, 32'd0);

        // branch while the request is still waiting, late ack must be dropped
        lat_min = 3; lat_max = 3;
        do_reset();
        cyc(0, 0, 0, 0, 32'd0, 32'd0);
        cyc(0, 0, 1, 0, 32'h200, 32'd0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);

        // branch + jump together, then a misaligned jump
        lat_min = 0; lat_max = 1;
        do_reset();
        cyc(0, 0, 0, 0, 32'd0, 32'd0);
        cyc(0, 0, 1, 1, 32'h100, 32'h300);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);
        cyc(0, 0, 0, 1, 32'd0, 32'h302);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);

        // reset while holding a buffered word
        lat_min = 0; lat_max = 0;
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 32'd0, 32'd0);
        cyc(1, 1, 0, 0, 32'd0, 32'd0);
        check_val("rst_hold_addr", bus.imem_addr_o, RST_PC);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 32'd0, 32'd0);

        // randomized traffic
        lat_min = 0; lat_max = 3;
        n_present = 0;
        lb = 1'b0; lj = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            s = ($urandom_range(3, 0) == 0);
            b = !lb && ($urandom_range(19, 0) == 0);
            j = !lj && ($urandom_range(19, 0) == 0);
            cyc(($urandom_range(499, 0) == 0), s, b, j, gen_target(), gen_target());
            lb = b; lj = j;
        end
        check_val("progress", {31'd0, (n_present > 300)}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
